dtc_dither_ctrl: RTL and testbench



---
 rtl/dtc_ctrl_pkg.sv | 33 +++
 rtl/dtc_lfsr.sv | 38 +++
 rtl/dtc_dither_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dtc_dither_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dtc_ctrl_pkg.sv
// Shared types, defaults and LFSR step function for the DTC dither control blocks.
package dtc_ctrl_pkg;

  // DTC code generation modes
  typedef enum logic [1:0] {
    DTC_FIX  = 2'd0,
    DTC_RAND = 2'd1,
    DTC_TRI  = 2'd2,
    DTC_HPF  = 2'd3
  } dtc_mode_e;

  // Triangle sweep direction
  typedef enum logic {
    TRI_UP   = 1'b0,
    TRI_DOWN = 1'b1
  } tri_dir_e;

  // Widest LFSR the step function supports; narrower states are zero-extended
  localparam int unsigned LFSR_MAX_W = 32;

  // x^16 + x^14 + x^13 + x^11 + 1, Galois right-shift form
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_SEED      = 16'hACE1;

  // One Galois step: shift right, fold the polynomial in when the lsb falls out
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] poly
  );
    lfsr_step = (state >> 1) ^ (state[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/dtc_lfsr.sv
// Parametrised Galois LFSR with advance enable and zero-seed guard.
// Ports:
//   i_clk   - clock, rising edge
//   i_nrst  - synchronous active-low reset, loads SEED (1 if SEED is 0)
//   i_en    - advance one step per clock while high
//   o_state - current LFSR state (registered)
module dtc_lfsr
  import dtc_ctrl_pkg::*;
#(
  parameter int unsigned   W    = 16,
  parameter logic [W-1:0]  POLY = W'(DEF_LFSR_POLY),
  parameter logic [W-1:0]  SEED = W'(DEF_SEED)
) (
  input  logic         i_clk,
  input  logic         i_nrst,
  input  logic         i_en,
  output logic [W-1:0] o_state
);

  // An all-zero state would lock the LFSR, so it is never loaded
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0]          r_state;
  logic [LFSR_MAX_W-1:0] w_next;

  assign w_next = lfsr_step(LFSR_MAX_W'(r_state), LFSR_MAX_W'(POLY));

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state <= SEED_EFF;
    end else if (i_en) begin
      r_state <= W'(w_next);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dtc_dither_ctrl.sv
// Per-edge DTC delay-code generator: fixed, uniform random, triangle sweep or
// first-order high-pass random code, plus offset and saturation to full-scale.
// Ports:
//   CLK       - clock, rising edge
//   NRST      - synchronous active-low reset (priority over EN)
//   EN        - produce one new code per clock while high
//   MODE      - 0 fixed, 1 uniform random, 2 triangle, 3 high-pass random
//   CODE_FIX  - code emitted in mode 0
//   CODE_OFST - offset added in modes 1-3
//   RANGE_MSK - dither range mask (contiguous low ones)
//   DTC_CODE  - registered DTC delay code
//   CODE_VLD  - DTC_CODE updated at the last edge
//   SAT       - DTC_CODE was clipped to full-scale
module dtc_dither_ctrl
  import dtc_ctrl_pkg::*;
#(
  parameter int unsigned        DW        = 6,
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_POLY = LFSR_W'(DEF_LFSR_POLY),
  parameter logic [LFSR_W-1:0]  SEED      = LFSR_W'(DEF_SEED)
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          EN,
  input  logic [1:0]    MODE,
  input  logic [DW-1:0] CODE_FIX,
  input  logic [DW-1:0] CODE_OFST,
  input  logic [DW-1:0] RANGE_MSK,
  output logic [DW-1:0] DTC_CODE,
  output logic          CODE_VLD,
  output logic          SAT
);

  localparam int unsigned DW1 = DW + 1;
  localparam int unsigned DW2 = DW + 2;
  localparam logic [DW2-1:0] FULL_SCALE = DW2'({DW{1'b1}});

  dtc_mode_e     r_mode_q;
  logic [DW-1:0] r_tri_cnt;
  tri_dir_e      r_tri_dir;
  logic [DW-1:0] r_prev;
  logic          r_first;
  logic [DW-1:0] r_code;
  logic          r_vld;
  logic          r_sat;

  logic [LFSR_W-1:0] w_lfsr;
  dtc_mode_e         w_mode;
  logic              w_mode_chg;
  logic [DW-1:0]     w_r;
  logic [DW-1:0]     w_tri_eff;
  tri_dir_e          w_dir_eff;
  logic [DW-1:0]     w_tri_nxt;
  tri_dir_e          w_dir_nxt;
  logic [DW-1:0]     w_prev_eff;
  logic              w_first_eff;
  logic [DW2-1:0]    w_hp_pos;
  logic [DW1-1:0]    w_d;
  logic [DW2-1:0]    w_sum;
  logic [DW-1:0]     w_code;
  logic              w_sat;

  // Random source; advances on every enabled clock regardless of mode
  dtc_lfsr #(
    .W    (LFSR_W),
    .POLY (LFSR_POLY),
    .SEED (SEED)
  ) u_lfsr (
    .i_clk   (CLK),
    .i_nrst  (NRST),
    .i_en    (EN),
    .o_state (w_lfsr)
  );

  assign w_mode     = dtc_mode_e'(MODE);
  assign w_mode_chg = (w_mode != r_mode_q);
  assign w_r        = w_lfsr[DW-1:0] & RANGE_MSK;

  // Mode-change state is applied combinationally so the new mode's first code
  // comes out in the change cycle itself
  always_comb begin
    w_tri_eff   = r_tri_cnt;
    w_dir_eff   = r_tri_dir;
    w_prev_eff  = r_prev;
    w_first_eff = r_first;
    if (w_mode_chg) begin
      w_tri_eff   = '0;
      w_dir_eff   = TRI_UP;
      w_prev_eff  = '0;
      w_first_eff = 1'b1;
    end else if (r_tri_cnt > RANGE_MSK) begin
      // Range shrank under the counter: restart the sweep from zero
      w_tri_eff = '0;
      w_dir_eff = TRI_UP;
    end
  end

  // Triangle sweep 0..M..0 with each endpoint emitted once
  always_comb begin
    w_tri_nxt = '0;
    w_dir_nxt = TRI_UP;
    if (RANGE_MSK == '0) begin
      w_tri_nxt = '0;
      w_dir_nxt = TRI_UP;
    end else if (w_dir_eff == TRI_UP) begin
      if (w_tri_eff == RANGE_MSK) begin
        w_tri_nxt = RANGE_MSK - DW'(1);
        w_dir_nxt = TRI_DOWN;
      end else begin
        w_tri_nxt = w_tri_eff + DW'(1);
        w_dir_nxt = TRI_UP;
      end
    end else begin
      if (w_tri_eff == '0) begin
        w_tri_nxt = DW'(1);
        w_dir_nxt = TRI_UP;
      end else begin
        w_tri_nxt = w_tri_eff - DW'(1);
        w_dir_nxt = TRI_DOWN;
      end
    end
  end

  // Pre-sum value, offset add and clip to full-scale
  always_comb begin
    w_d      = '0;
    w_code   = '0;
    w_sat    = 1'b0;
    w_hp_pos = DW2'(w_r) + DW2'(RANGE_MSK);
    unique case (w_mode)
      DTC_RAND: w_d = DW1'(w_r);
      DTC_TRI:  w_d = DW1'(w_tri_eff);
      DTC_HPF: begin
        if (w_first_eff) begin
          w_d = DW1'(w_r);
        end else if (w_hp_pos < DW2'(w_prev_eff)) begin
          // Only reachable if the mask shrank mid-run; clamp rather than wrap
          w_d = '0;
        end else begin
          w_d = DW1'(w_hp_pos - DW2'(w_prev_eff));
        end
      end
      default:  w_d = '0;
    endcase
    w_sum = DW2'(CODE_OFST) + DW2'(w_d);
    if (w_mode == DTC_FIX) begin
      w_code = CODE_FIX;
      w_sat  = 1'b0;
    end else if (w_sum > FULL_SCALE) begin
      w_code = {DW{1'b1}};
      w_sat  = 1'b1;
    end else begin
      w_code = DW'(w_sum);
      w_sat  = 1'b0;
    end
  end

  // Mode tracking, dither state and output registers
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      r_mode_q  <= w_mode;
      r_tri_cnt <= '0;
      r_tri_dir <= TRI_UP;
      r_prev    <= '0;
      r_first   <= 1'b1;
      r_code    <= '0;
      r_vld     <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_mode_q <= w_mode;
      r_vld    <= EN;
      if (w_mode_chg) begin
        r_tri_cnt <= '0;
        r_tri_dir <= TRI_UP;
        r_prev    <= '0;
        r_first   <= 1'b1;
      end
      if (EN) begin
        r_code <= w_code;
        r_sat  <= w_sat;
        if (w_mode == DTC_TRI) begin
          r_tri_cnt <= w_tri_nxt;
          r_tri_dir <= w_dir_nxt;
        end
        if (w_mode == DTC_HPF) begin
          r_prev  <= w_r;
          r_first <= 1'b0;
        end
      end
    end
  end

  assign DTC_CODE = r_code;
  assign CODE_VLD = r_vld;
  assign SAT      = r_sat;

endmodule

// File: tb/tb_dtc_dither_ctrl.sv
// Directed self-checking bench for dtc_dither_ctrl (DW=6, default LFSR/seed).
module tb_dtc_dither_ctrl;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       EN;
  logic [1:0] MODE;
  logic [5:0] CODE_FIX;
  logic [5:0] CODE_OFST;
  logic [5:0] RANGE_MSK;
  logic [5:0] DTC_CODE;
  logic       CODE_VLD;
  logic       SAT;

  int total = 0;
  int bad   = 0;

  dtc_dither_ctrl dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .EN        (EN),
    .MODE      (MODE),
    .CODE_FIX  (CODE_FIX),
    .CODE_OFST (CODE_OFST),
    .RANGE_MSK (RANGE_MSK),
    .DTC_CODE  (DTC_CODE),
    .CODE_VLD  (CODE_VLD),
    .SAT       (SAT)
  );

  always #5 CLK = ~CLK;

  // Independent Galois step for the x^16+x^14+x^13+x^11+1 register
  function automatic logic [15:0] mstep(input logic [15:0] s);
    mstep = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int code, input int vld, input int sat);
    check({tag, ".code"}, 8'(DTC_CODE), 8'(code));
    check({tag, ".vld"},  8'(CODE_VLD), 8'(vld));
    check({tag, ".sat"},  8'(SAT),      8'(sat));
  endtask

  initial begin
    logic [15:0] m;
    int          r;
    int          rp;
    int          d;
    int          exp_tri [9];
    exp_tri = '{10, 11, 12, 13, 12, 11, 10, 11, 12};

    // Reset with EN high
    NRST = 1'b0; EN = 1'b1; MODE = 2'd1;
    CODE_FIX = 6'd0; CODE_OFST = 6'd0; RANGE_MSK = 6'h3F;
    tick(); tick();
    check_out("reset", 0, 0, 0);

    // Hold with EN low: nothing moves
    NRST = 1'b1; EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("hold", 0, 0, 0);
    end

    // Uniform random, full range, no offset
    EN = 1'b1;
    m  = 16'hACE1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i == 0) check("rand.first", 8'(DTC_CODE), 8'd33);
      if (i == 1) check("rand.second", 8'(DTC_CODE), 8'd48);
      check_out("rand", int'(m[5:0]), 1, 0);
      m = mstep(m);
    end

    // Fixed mode with EN toggling
    MODE = 2'd0; CODE_FIX = 6'd17;
    tick(); check_out("fix.a", 17, 1, 0); m = mstep(m);
    EN = 1'b0;
    tick(); check_out("fix.b", 17, 0, 0);
    EN = 1'b1;
    tick(); check_out("fix.c", 17, 1, 0); m = mstep(m);

    // Back to random: LFSR sequence continues
    MODE = 2'd1;
    tick(); check_out("rand.resume", int'(m[5:0]), 1, 0); m = mstep(m);

    // Saturation with offset 60
    CODE_OFST = 6'd60;
    for (int i = 0; i < 100; i++) begin
      tick();
      r = int'(m[5:0]);
      if (r > 3) check_out("sat.clip", 63, 1, 1);
      else       check_out("sat.pass", 60 + r, 1, 0);
      m = mstep(m);
    end

    // High-pass random from a fresh reset
    NRST = 1'b0; MODE = 2'd3; CODE_OFST = 6'd0; RANGE_MSK = 6'h3F;
    tick();
    NRST = 1'b1;
    m = 16'hACE1;
    tick(); check_out("hpf.first", 33, 1, 0);
    tick(); check_out("hpf.second", 63, 1, 1);
    m  = mstep(mstep(m));
    rp = 48;
    for (int i = 0; i < 20; i++) begin
      tick();
      r = int'(m[5:0]);
      d = r + 63 - rp;
      check_out("hpf.run", (d > 63) ? 63 : d, 1, (d > 63) ? 1 : 0);
      rp = r;
      m  = mstep(m);
    end

    // Mode 0 then re-enter mode 3: first code is r again
    MODE = 2'd0; CODE_FIX = 6'd5;
    tick(); check_out("hpf.fix", 5, 1, 0); m = mstep(m);
    MODE = 2'd3;
    tick(); r = int'(m[5:0]); check_out("hpf.reentry", r, 1, 0);
    rp = r; m = mstep(m);
    tick(); r = int'(m[5:0]); d = r + 63 - rp;
    check_out("hpf.after", (d > 63) ? 63 : d, 1, (d > 63) ? 1 : 0);

    // Triangle sweep, MSK=3, offset 10
    MODE = 2'd2; RANGE_MSK = 6'd3; CODE_OFST = 6'd10;
    for (int i = 0; i < 9; i++) begin
      tick();
      check_out("tri.sweep", exp_tri[i], 1, 0);
    end
    // Counter now 3, above the new mask: restart at 0
    RANGE_MSK = 6'd1;
    tick(); check_out("tri.shrink0", 10, 1, 0);
    tick(); check_out("tri.shrink1", 11, 1, 0);
    tick(); check_out("tri.shrink2", 10, 1, 0);
    tick(); check_out("tri.shrink3", 11, 1, 0);
    // Zero mask pins the counter
    RANGE_MSK = 6'd0;
    tick(); check_out("tri.zero0", 10, 1, 0);
    tick(); check_out("tri.zero1", 10, 1, 0);

    // Reset mid-operation has priority over EN
    NRST = 1'b0; EN = 1'b1;
    tick(); check_out("reset.mid", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
